io_bridge: RTL
==============

// Module: io_bridge
// PURPOSE
//  Data-side bus bridge between the CPU load/store port and DRAM plus the MMIO peripherals.
//  Decodes cpu_addr, steers writes to DRAM or the LED block, and returns read data one cycle later.
//  Synchronises the switch and button inputs, and hosts an optional free-running timer.
//  Sits directly upstream of the LED block: it drives led_addr, led_we and led_raw_wdata.
// PARAMETERS
//  PERIPH_BASE 32'hFFFF_F000  MMIO region base; hit when cpu_addr[31:12]==PERIPH_BASE[31:12]
//  LED_ADDR    32'hFFFF_F060  LED register (write-only; reads return 0)
//  SW_ADDR     32'hFFFF_F070  switch register (read-only)
//  BTN_ADDR    32'hFFFF_F078  button register (read-only)
//  TIMER_ADDR  32'hFFFF_F020  timer count (read/write; only with IO_BRIDGE_TIMER_EN)
//  TIMER_DIV   32'd100        prescaler: the timer counts once every TIMER_DIV clocks (must be >=1)
// PORTS
//  bridge_clk    in   1   system clock
//  bridge_rst    in   1   asynchronous reset, active-high
//  cpu_addr      in   32  byte address of the load/store
//  cpu_we        in   1   store strobe (one cycle per store)
//  cpu_re        in   1   load strobe
//  cpu_wdata     in   32  store data
//  cpu_rdata     out  32  load data, valid in the cycle after cpu_re
//  dram_addr     out  32  = cpu_addr
//  dram_we       out  1   store strobe to DRAM
//  dram_wdata    out  32  = cpu_wdata
//  dram_rdata    in   32  DRAM data; synchronous BRAM, 1-cycle latency
//  led_addr      out  32  = cpu_addr
//  led_we        out  1   store strobe to the LED block
//  led_raw_wdata out  32  = cpu_wdata
//  sw_in         in   16  raw switch pins (asynchronous)
//  btn_in        in   5   raw button pins (asynchronous)
// BEHAVIOUR
//  - Decode (combinational): periph_hit = cpu_addr[31:12]==PERIPH_BASE[31:12]; DRAM otherwise.
//  - dram_we = cpu_we & ~periph_hit.
//  - led_we  = cpu_we & (cpu_addr==LED_ADDR).
//  - Stores to any other MMIO address are dropped: no strobe is asserted.
//  - Read select: sel_q <= {SEL_DRAM,SEL_PERIPH} every clock, taken from cpu_addr.
//  - Peripheral read data: periph_rdata_q <= mux(cpu_addr) every clock.
//    SW  = {16'b0, sw_sync}; BTN = {27'b0, btn_sync}; TIMER = timer_q; else 0.
//  - cpu_rdata = (sel_q==SEL_PERIPH) ? periph_rdata_q : dram_rdata. Latency 1 for both paths.
//  - Back-to-back loads are supported with one result per cycle; no stall and no handshake.
//  - Input sync: sw_in and btn_in each go through a 2-FF synchroniser.
//    A pin change is visible on a load issued 2 cycles after the change, read back at +3.
//  - Reset values: sel_q=SEL_DRAM, periph_rdata_q=0, sync flops=0, timer_q=0, presc_q=0.
//    All strobes are combinational and are 0 whenever cpu_we=0.
//  - Reset mid-load: the result is lost; the first cycle after release returns dram_rdata.
//  - Simultaneous load and store to the same address: the store strobe is passed through,
//    and the load returns the pre-store value.
// CONFIGURATION
//  IO_BRIDGE_TIMER_EN defined:
//    - presc_q counts 0..TIMER_DIV-1; at wrap, timer_q increments, 32'hFFFF_FFFF -> 0.
//    - A store to TIMER_ADDR loads timer_q<=cpu_wdata and presc_q<=0.
//      The store wins over a same-cycle increment.
//  IO_BRIDGE_TIMER_EN undefined:
//    - No timer flops. TIMER_ADDR is unmapped: reads return 0 and stores are dropped.
// STRUCTURE
//  Shared package io_map_pkg:
//    - the *_ADDR and PERIPH_BASE constants;
//    - the sel_t enum {SEL_DRAM, SEL_PERIPH}.
//  The LED block and the top level include the same package.
//  One sub-module, io_sync2 (parameterised width, 2-FF synchroniser), instantiated for sw and btn.
//  The timer is inline, inside an `ifdef block.
// TESTING
//  1 Store 0x0000_A5A5 to 0xFFFF_F060 -> led_we=1 for 1 cycle with led_raw_wdata=0xA5A5, dram_we=0.
//  2 Store to 0x0000_0040, then load 0x0000_0040 -> dram_we=1, led_we=0.
//    Load result = dram_rdata in the next cycle.
//  3 sw_in=0x1234 held; load SW_ADDR issued >=2 cycles later -> cpu_rdata=0x0000_1234 at +1.
//    A load of 0xFFFF_F0FC returns 0.
//  4 Alternate loads DRAM/SW/DRAM on consecutive cycles -> correct source each cycle, no bubbles.
//  5 TIMER_EN, TIMER_DIV=4:
//    - store 0xFFFF_FFFE -> timer reads 0xFFFF_FFFF after 4 clks, 0 after 8;
//    - a store on the wrap cycle wins.
//  6 Assert bridge_rst during a pending SW load -> cpu_rdata follows dram_rdata.
//    sw_sync, timer and prescaler read back 0 after release.

Source files
------------

// File: rtl/io_map_pkg.sv
// Shared memory map for the data-side bus: MMIO constants and the read-source select type.
// Imported by io_bridge and by the LED block downstream of it.
package io_map_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;
  localparam logic [31:0] LED_ADDR    = 32'hFFFF_F060;
  localparam logic [31:0] SW_ADDR     = 32'hFFFF_F070;
  localparam logic [31:0] BTN_ADDR    = 32'hFFFF_F078;
  localparam logic [31:0] TIMER_ADDR  = 32'hFFFF_F020;

  typedef enum logic {
    SEL_DRAM   = 1'b0,
    SEL_PERIPH = 1'b1
  } sel_t;

  function automatic logic is_periph(input logic [31:0] addr);
    return addr[31:12] == PERIPH_BASE[31:12];
  endfunction

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchroniser for asynchronous input pins; width set by WIDTH.
module io_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/io_bridge.sv
// Data-side bridge: CPU load/store port to DRAM, LED, switch and button registers.
// Optional free-running timer at TIMER_ADDR when IO_BRIDGE_TIMER_EN is defined.
module io_bridge
  import io_map_pkg::*;
#(
  parameter int unsigned TIMER_DIV = 100
) (
  input  logic        bridge_clk,
  input  logic        bridge_rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic [31:0] dram_addr,
  output logic        dram_we,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  output logic [31:0] led_addr,
  output logic        led_we,
  output logic [31:0] led_raw_wdata,
  input  logic [15:0] sw_in,
  input  logic [4:0]  btn_in
);

  logic        periph_hit;
  logic [15:0] sw_sync;
  logic [4:0]  btn_sync;
  logic [31:0] timer_rd;
  logic [31:0] periph_rdata_d;
  logic [31:0] periph_rdata_q;
  sel_t        sel_q;

  // Loads are unconditionally registered every cycle, so the load strobe carries no extra information.
  logic unused_cpu_re;
  assign unused_cpu_re = cpu_re;

  assign periph_hit    = is_periph(cpu_addr);
  assign dram_addr     = cpu_addr;
  assign dram_wdata    = cpu_wdata;
  assign led_addr      = cpu_addr;
  assign led_raw_wdata = cpu_wdata;
  assign dram_we       = cpu_we & ~periph_hit;
  assign led_we        = cpu_we & (cpu_addr == LED_ADDR);

  io_sync2 #(.WIDTH(16)) u_sw_sync (
    .clk (bridge_clk),
    .rst (bridge_rst),
    .d   (sw_in),
    .q   (sw_sync)
  );

  io_sync2 #(.WIDTH(5)) u_btn_sync (
    .clk (bridge_clk),
    .rst (bridge_rst),
    .d   (btn_in),
    .q   (btn_sync)
  );

`ifdef IO_BRIDGE_TIMER_EN
  localparam int unsigned PRESC_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [PRESC_W-1:0] presc_q;
  logic [31:0]        timer_q;
  logic               presc_wrap;
  logic               timer_wr;

  assign presc_wrap = (presc_q == PRESC_W'(TIMER_DIV - 1));
  assign timer_wr   = cpu_we & (cpu_addr == TIMER_ADDR);

  // A CPU store takes priority over the prescaler tick in the same cycle.
  always_ff @(posedge bridge_clk or posedge bridge_rst) begin
    if (bridge_rst) begin
      presc_q <= '0;
      timer_q <= '0;
    end else if (timer_wr) begin
      presc_q <= '0;
      timer_q <= cpu_wdata;
    end else if (presc_wrap) begin
      presc_q <= '0;
      timer_q <= timer_q + 32'd1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif

  always_comb begin
    periph_rdata_d = '0;
    case (cpu_addr)
      SW_ADDR:    periph_rdata_d = {16'b0, sw_sync};
      BTN_ADDR:   periph_rdata_d = {27'b0, btn_sync};
      TIMER_ADDR: periph_rdata_d = timer_rd;
      default:    periph_rdata_d = '0;
    endcase
  end

  // Read stage: source select and peripheral data line up with the BRAM's one-cycle latency.
  always_ff @(posedge bridge_clk or posedge bridge_rst) begin
    if (bridge_rst) begin
      sel_q          <= SEL_DRAM;
      periph_rdata_q <= '0;
    end else begin
      sel_q          <= periph_hit ? SEL_PERIPH : SEL_DRAM;
      periph_rdata_q <= periph_rdata_d;
    end
  end

  assign cpu_rdata = (sel_q == SEL_PERIPH) ? periph_rdata_q : dram_rdata;

endmodule
